// File: rtl/cpu_div_cell_if.sv
// ---------------------------------------------------------------------------
// cpu_div_cell_if : operand/handshake/result bundle for the iterative divider
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface cpu_div_cell_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] E_src1;
  logic [WIDTH-1:0] E_src2;
  logic             div_start;
  logic             div_signed;
  logic             div_flush;
  logic             div_busy;
  logic             div_done;
  logic [WIDTH-1:0] div_quot;
  logic [WIDTH-1:0] div_rem;
  logic             div_by_zero;

  modport master (
    output E_src1, E_src2, div_start, div_signed, div_flush,
    input  div_busy, div_done, div_quot, div_rem, div_by_zero
  );

  modport slave (
    input  E_src1, E_src2, div_start, div_signed, div_flush,
    output div_busy, div_done, div_quot, div_rem, div_by_zero
  );
endinterface

`default_nettype wire

// File: rtl/cpu_div_cell.sv
// ---------------------------------------------------------------------------
// cpu_div_cell : radix-2 restoring DIV/DIVU, quotient and remainder, fixed latency
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cpu_div_cell #(
  parameter int WIDTH = 32
) (
  input  wire logic        clk,
  input  wire logic        reset,
  cpu_div_cell_if.slave    bus
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             is_signed;
  logic [WIDTH-1:0] dq;        // dividend shifts out the top, quotient bits shift in
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] prem;
  logic             q_neg;
  logic             r_neg;
  logic             dbz;
  logic [CNT_W-1:0] cnt;

  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem_out;
  logic             by_zero;

  logic             sign1;
  logic             sign2;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  always_comb begin
    sign1    = is_signed & src1[WIDTH-1];
    sign2    = is_signed & src2[WIDTH-1];
    mag1     = sign1 ? (~src1 + 1'b1) : src1;
    mag2     = sign2 ? (~src2 + 1'b1) : src2;
    // prem < 2^(WIDTH-1) before every shift, so its MSB can be dropped safely
    trial    = {1'b0, prem[WIDTH-2:0], dq[WIDTH-1]} - {1'b0, dsr};
    quot_fix = q_neg ? (~dq + 1'b1) : dq;
    rem_fix  = r_neg ? (~prem + 1'b1) : prem;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      src1      <= '0;
      src2      <= '0;
      is_signed <= 1'b0;
      dq        <= '0;
      dsr       <= '0;
      prem      <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      dbz       <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quot      <= '0;
      rem_out   <= '0;
      by_zero   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.div_flush && (state != S_IDLE)) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            // a start coinciding with the done pulse is dropped
            if (bus.div_start && !bus.div_flush && !done) begin
              src1      <= bus.E_src1;
              src2      <= bus.E_src2;
              is_signed <= bus.div_signed;
              busy      <= 1'b1;
              state     <= S_LOAD;
            end
          end
          S_LOAD: begin
            dq    <= mag1;
            dsr   <= mag2;
            q_neg <= sign1 ^ sign2;
            r_neg <= sign1;
            dbz   <= (src2 == '0);
            prem  <= '0;
            cnt   <= '0;
            state <= S_RUN;
          end
          S_RUN: begin
            if (!trial[WIDTH]) begin
              prem <= trial[WIDTH-1:0];
            end else begin
              prem <= {prem[WIDTH-2:0], dq[WIDTH-1]};
            end
            dq  <= {dq[WIDTH-2:0], ~trial[WIDTH]};
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state <= S_FIX;
            end
          end
          S_FIX: begin
            if (dbz) begin
              quot    <= '1;
              rem_out <= src1;
            end else begin
              quot    <= quot_fix;
              rem_out <= rem_fix;
            end
            by_zero <= dbz;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.div_busy    = busy;
  assign bus.div_done    = done;
  assign bus.div_quot    = quot;
  assign bus.div_rem     = rem_out;
  assign bus.div_by_zero = by_zero;

endmodule

`default_nettype wire

// File: tb/tb_cpu_div_cell.sv
// ---------------------------------------------------------------------------
// tb_cpu_div_cell : directed + random DIV/DIVU checks against an arithmetic model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cpu_div_cell;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  logic [W-1:0] prev_q;
  logic [W-1:0] prev_r;
  logic         prev_z;

  cpu_div_cell_if #(.WIDTH(W)) bus ();

  cpu_div_cell #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, 64-bit so that MIN/-1 wraps naturally
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    longint sa;
    longint sb;
    z = (b == '0);
    if (z) begin
      q = '1;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;
    int           n;
    int           busy_n;
    logic         held;
    logic         seen;
    model(a, b, sgn, eq, er, ez);
    bus.E_src1     = a;
    bus.E_src2     = b;
    bus.div_signed = sgn;
    bus.div_start  = 1'b1;
    @(posedge clk); #1;
    bus.div_start = 1'b0;
    busy_n = bus.div_busy ? 1 : 0;
    held   = 1'b1;
    seen   = 1'b0;
    for (n = 1; n <= 100; n++) begin
      if (n == 5) begin
        bus.div_start  = 1'b1;
        bus.E_src1     = $urandom;
        bus.E_src2     = $urandom;
        bus.div_signed = ~sgn;
      end
      if (n == 6) bus.div_start = 1'b0;
      @(posedge clk); #1;
      if (bus.div_busy) busy_n++;
      if (bus.div_done) begin
        seen = 1'b1;
        break;
      end
      if (bus.div_quot !== prev_q || bus.div_rem !== prev_r || bus.div_by_zero !== prev_z)
        held = 1'b0;
    end
    check("done_seen", 64'(seen), 64'd1);
    check("latency", 64'(n), 64'(LAT));
    check("busy_cycles", 64'(busy_n), 64'(LAT));
    check("held_during_run", 64'(held), 64'd1);
    check("quot", 64'(bus.div_quot), 64'(eq));
    check("rem", 64'(bus.div_rem), 64'(er));
    check("by_zero", 64'(bus.div_by_zero), 64'(ez));
    prev_q = eq;
    prev_r = er;
    prev_z = ez;
    // start during the done cycle must be ignored
    bus.E_src1    = $urandom;
    bus.E_src2    = $urandom;
    bus.div_start = 1'b1;
    @(posedge clk); #1;
    bus.div_start = 1'b0;
    check("done_one_pulse", 64'(bus.div_done), 64'd0);
    check("start_on_done_ignored", 64'(bus.div_busy), 64'd0);
  endtask

  initial begin
    logic flush_ok;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    n_checks = 0;
    n_errors = 0;
    prev_q = '0;
    prev_r = '0;
    prev_z = 1'b0;
    bus.E_src1     = '0;
    bus.E_src2     = '0;
    bus.div_start  = 1'b0;
    bus.div_signed = 1'b0;
    bus.div_flush  = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_quot", 64'(bus.div_quot), 64'd0);
    check("rst_rem", 64'(bus.div_rem), 64'd0);
    check("rst_busy", 64'(bus.div_busy), 64'd0);
    check("rst_done", 64'(bus.div_done), 64'd0);
    check("rst_dbz", 64'(bus.div_by_zero), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(32'd100, 32'd7, 1'b0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op(32'hFFFF_FFFB, 32'd0, 1'b1);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b0);

    // flush mid-operation
    bus.E_src1     = 32'd1000;
    bus.E_src2     = 32'd10;
    bus.div_signed = 1'b0;
    bus.div_start  = 1'b1;
    @(posedge clk); #1;
    bus.div_start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    bus.div_flush = 1'b1;
    @(posedge clk); #1;
    bus.div_flush = 1'b0;
    check("flush_busy_low", 64'(bus.div_busy), 64'd0);
    flush_ok = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.div_done || bus.div_busy || bus.div_quot !== prev_q ||
          bus.div_rem !== prev_r || bus.div_by_zero !== prev_z)
        flush_ok = 1'b0;
    end
    check("flush_no_done_outputs_held", 64'(flush_ok), 64'd1);

    // flush wins over start in IDLE
    bus.div_start = 1'b1;
    bus.div_flush = 1'b1;
    @(posedge clk); #1;
    bus.div_start = 1'b0;
    bus.div_flush = 1'b0;
    check("idle_flush_wins", 64'(bus.div_busy), 64'd0);
    run_op(32'd9, 32'd3, 1'b0);

    // randomized operands, biased toward small and zero divisors
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom;
        1:       rb = W'($urandom_range(0, 20));
        2:       rb = -W'($urandom_range(1, 20));
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      if (i % 8 == 3) ra = 32'h8000_0000;
      run_op(ra, rb, 1'($urandom_range(0, 1)));
    end

    // asynchronous reset mid-RUN
    bus.E_src1     = 32'h1234_5678;
    bus.E_src2     = 32'h11;
    bus.div_signed = 1'b0;
    bus.div_start  = 1'b1;
    @(posedge clk); #1;
    bus.div_start = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_quot", 64'(bus.div_quot), 64'd0);
    check("async_rst_rem", 64'(bus.div_rem), 64'd0);
    check("async_rst_busy", 64'(bus.div_busy), 64'd0);
    check("async_rst_dbz", 64'(bus.div_by_zero), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    prev_q = '0;
    prev_r = '0;
    prev_z = 1'b0;
    flush_ok = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.div_done || bus.div_busy) flush_ok = 1'b0;
    end
    check("reset_no_done", 64'(flush_ok), 64'd1);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
